// File: rtl/data_memory.sv
// RV32 data memory: req/ready handshake, WAIT_CYCLES wait states, byte/half/word access with sign/zero extension.
// Optional feature macro: MEM_MISALIGN_EN (report misaligned half/word accesses on error).
module data_memory #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              write_enable,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              ready,
    output logic              valid,
    output logic [31:0]       read_data,
    output logic              error
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              ready_r, valid_r, error_r;
    logic [31:0]       read_data_r;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wd_r;
    logic [31:0]       mem_r [DEPTH] = '{default: 32'd0};

    logic              accept_s, commit_s;
    logic              op_we_s;
    logic [2:0]        op_f3_s;
    logic [ADDR_W-1:0] op_addr_s;
    logic [31:0]       op_wd_s;
    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic [31:0]       word_s, load_s, wdata_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [3:0]        be_s;
    logic              illegal_s, misalign_s, err_s;
    logic              unused_s;

    assign accept_s = req && ready_r;
    assign commit_s = (state_s == ST_RESP);
    assign unused_s = ^{addr_r[ADDR_W-1:IDX_W+2], addr[ADDR_W-1:IDX_W+2]};

    // Next-state and wait-state counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (WAIT_CYCLES == 0) begin
                        state_s = ST_RESP;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(WAIT_CYCLES);
                    end
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // With no wait states the commit edge is the accept edge, so the live inputs are the operation
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            op_we_s   = write_enable;
            op_f3_s   = funct3;
            op_addr_s = addr;
            op_wd_s   = write_data;
        end else begin
            op_we_s   = we_r;
            op_f3_s   = f3_r;
            op_addr_s = addr_r;
            op_wd_s   = wd_r;
        end
    end

    // Width decode, legality, lane selection and load extension
    always_comb begin
        idx_s   = op_addr_s[IDX_W+1:2];
        lane_s  = op_addr_s[1:0];
        word_s  = mem_r[idx_s];
        byte_s  = word_s[{lane_s, 3'b000} +: 8];
        half_s  = op_addr_s[1] ? word_s[31:16] : word_s[15:0];
        load_s  = 32'd0;
        wdata_s = op_wd_s;
        be_s    = 4'b0000;
        illegal_s = 1'b0;
        case (op_f3_s)
            3'b000: begin
                load_s  = {{24{byte_s[7]}}, byte_s};
                wdata_s = {4{op_wd_s[7:0]}};
                be_s    = 4'b0001 << lane_s;
            end
            3'b001: begin
                load_s  = {{16{half_s[15]}}, half_s};
                wdata_s = {2{op_wd_s[15:0]}};
                be_s    = op_addr_s[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                load_s  = word_s;
                wdata_s = op_wd_s;
                be_s    = 4'b1111;
            end
            3'b100: begin
                load_s    = {24'd0, byte_s};
                illegal_s = op_we_s;
            end
            3'b101: begin
                load_s    = {16'd0, half_s};
                illegal_s = op_we_s;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
`ifdef MEM_MISALIGN_EN
        misalign_s = ((op_f3_s[1:0] == 2'b01) && op_addr_s[0]) ||
                     ((op_f3_s[1:0] == 2'b10) && (op_addr_s[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        err_s = illegal_s || misalign_s;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            f3_r   <= 3'd0;
            addr_r <= '0;
            wd_r   <= 32'd0;
        end else if (accept_s) begin
            we_r   <= write_enable;
            f3_r   <= funct3;
            addr_r <= addr;
            wd_r   <= write_data;
        end
    end

    // Registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            error_r     <= 1'b0;
            read_data_r <= 32'd0;
        end else begin
            ready_r <= (state_s != ST_WAIT);
            valid_r <= commit_s;
            error_r <= commit_s && err_s;
            if (commit_s) begin
                read_data_r <= (err_s || op_we_s) ? 32'd0 : load_s;
            end
        end
    end

    // Byte-strobed store on the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_s && op_we_s && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
                end
            end
        end
    end

    assign ready     = ready_r;
    assign valid     = valid_r;
    assign error     = error_r;
    assign read_data = read_data_r;
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
// Expected responses come from a byte-array reference model; a monitor per instance checks them.
module tb_data_memory;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic        req_v   [2];
    logic        we_v    [2];
    logic [2:0]  f3_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wd_v    [2];
    logic        ready_v [2];
    logic        valid_v [2];
    logic        error_v [2];
    logic [31:0] rdata_v [2];

    int          wc_v [2] = '{1, 0};
    bit [7:0]    mb [2][4096];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_v[0]), .req(req_v[0]), .write_enable(we_v[0]),
        .funct3(f3_v[0]), .addr(addr_v[0]), .write_data(wd_v[0]),
        .ready(ready_v[0]), .valid(valid_v[0]), .read_data(rdata_v[0]), .error(error_v[0])
    );

    data_memory #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_v[1]), .req(req_v[1]), .write_enable(we_v[1]),
        .funct3(f3_v[1]), .addr(addr_v[1]), .write_data(wd_v[1]),
        .ready(ready_v[1]), .valid(valid_v[1]), .read_data(rdata_v[1]), .error(error_v[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory of DEPTH*4 bytes, accesses by size
    task automatic model(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output bit [31:0] rd, output bit err);
        int     size;
        int     base;
        longint v;
        rd = 32'd0;
        err = 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || (we && f3[2])) begin
            err = 1'b1;
            return;
        end
        base = int'(a % 32'd4096);
`ifdef MEM_MISALIGN_EN
        if (base % size != 0) begin
            err = 1'b1;
            return;
        end
`endif
        base = base - (base % size);
        if (we) begin
            for (int i = 0; i < size; i++) mb[d][base + i] = 8'(wd >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(mb[d][base + i]) << (8 * i));
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            rd = 32'(v);
        end
    endtask

    task automatic issue(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit use_k = 1'b0,
                         input bit [31:0] k_rd = 32'd0, input bit k_err = 1'b0);
        exp_t      e;
        bit [31:0] mrd;
        bit        merr;
        int        n;
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = we; f3_v[d] = f3; addr_v[d] = a; wd_v[d] = wd;
        n = 0;
        while (!ready_v[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ready_v[d]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d: got ready=0 want ready=1", d);
            req_v[d] = 1'b0;
            return;
        end
        model(d, we, f3, a, wd, mrd, merr);
        e.rd  = use_k ? k_rd : mrd;
        e.err = use_k ? k_err : merr;
        e.acc = cyc;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_v[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_dut%0d", d), (d == 0) ? q0.size() : q1.size(), 32'd0);
    endtask

    task automatic mon_step(input int d);
        exp_t e;
        if (valid_v[d]) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid dut%0d: got valid=1 want valid=0 (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("read_data_dut%0d", d), rdata_v[d], e.rd);
                chk($sformatf("error_dut%0d", d), {31'd0, error_v[d]}, {31'd0, e.err});
                chk($sformatf("latency_dut%0d", d), cyc - e.acc, wc_v[d] + 1);
            end
        end else begin
            chk($sformatf("error_without_valid_dut%0d", d), {31'd0, error_v[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) if (rst_v[0]) mon_step(0);
    always @(negedge clk) if (rst_v[1]) mon_step(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        bit [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0; req_v[d] = 1'b0; we_v[d] = 1'b0;
            f3_v[d] = 3'd0; addr_v[d] = 32'd0; wd_v[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'd0, ready_v[d]}, 32'd0);
            chk("reset_valid", {31'd0, valid_v[d]}, 32'd0);
            chk("reset_error", {31'd0, error_v[d]}, 32'd0);
            chk("reset_read_data", rdata_v[d], 32'd0);
        end
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'd0, ready_v[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge0", {31'd0, ready_v[0]}, 32'd1);
        chk("ready_after_first_edge1", {31'd0, ready_v[1]}, 32'd1);

        // Directed scenarios, WAIT_CYCLES=1
        issue(0, 1, 3'd2, 32'h4,    32'hDEADBEEF, 1, 32'h0,        0);
        issue(0, 0, 3'd2, 32'h4,    32'h0,        1, 32'hDEADBEEF, 0);
        issue(0, 1, 3'd0, 32'h9,    32'hFFFFFFA5, 1, 32'h0,        0);
        issue(0, 0, 3'd0, 32'h9,    32'h0,        1, 32'hFFFFFFA5, 0);
        issue(0, 0, 3'd4, 32'h9,    32'h0,        1, 32'h000000A5, 0);
        issue(0, 0, 3'd2, 32'h8,    32'h0,        1, 32'h0000A500, 0);
        issue(0, 1, 3'd1, 32'h6,    32'h12348001, 1, 32'h0,        0);
        issue(0, 0, 3'd1, 32'h6,    32'h0,        1, 32'hFFFF8001, 0);
        issue(0, 0, 3'd5, 32'h6,    32'h0,        1, 32'h00008001, 0);
        issue(0, 0, 3'd2, 32'h4,    32'h0,        1, 32'h8001BEEF, 0);
        issue(0, 0, 3'd2, 32'h20,   32'h0,        1, 32'h0,        0);
        issue(0, 0, 3'd2, 32'h1004, 32'h0,        1, 32'h8001BEEF, 0);
        issue(0, 0, 3'd3, 32'h0,    32'h0,        1, 32'h0,        1);
        issue(0, 1, 3'd4, 32'h4,    32'hFFFFFFFF, 1, 32'h0,        1);
        issue(0, 0, 3'd2, 32'h4,    32'h0,        1, 32'h8001BEEF, 0);
`ifdef MEM_MISALIGN_EN
        issue(0, 0, 3'd2, 32'h5,    32'h0,        1, 32'h0,        1);
        issue(0, 1, 3'd2, 32'h5,    32'h0,        1, 32'h0,        1);
        issue(0, 0, 3'd2, 32'h4,    32'h0,        1, 32'h8001BEEF, 0);
`else
        issue(0, 0, 3'd2, 32'h5,    32'h0,        1, 32'h8001BEEF, 0);
        issue(0, 1, 3'd2, 32'h5,    32'h0,        1, 32'h0,        0);
        issue(0, 0, 3'd2, 32'h4,    32'h0,        1, 32'h0,        0);
`endif
        idle(0);
        drain(0);

        // Reset during WAIT aborts the store and keeps the array
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; f3_v[0] = 3'd2; addr_v[0] = 32'hC; wd_v[0] = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        rst_v[0] = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready_v[0]}, 32'd0);
        chk("abort_valid", {31'd0, valid_v[0]}, 32'd0);
        chk("abort_error", {31'd0, error_v[0]}, 32'd0);
        chk("abort_read_data", rdata_v[0], 32'd0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_abort", {31'd0, ready_v[0]}, 32'd1);
        issue(0, 0, 3'd2, 32'hC, 32'h0, 1, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h1004, 32'h0);

        // Randomized traffic with occasional idle gaps
        repeat (80) begin
            a = $urandom & 32'hFFFF_F03F;
            issue(0, 1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 9)], a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(0);
        end
        idle(0);

        // WAIT_CYCLES=0: back-to-back accepts, one valid per cycle
        issue(1, 1, 3'd2, 32'h0, 32'h11111111);
        issue(1, 1, 3'd2, 32'h4, 32'h22222222);
        issue(1, 1, 3'd2, 32'h8, 32'h33333333);
        issue(1, 1, 3'd2, 32'hC, 32'h44444444);
        issue(1, 0, 3'd2, 32'h0, 32'h0, 1, 32'h11111111, 0);
        issue(1, 0, 3'd2, 32'h4, 32'h0, 1, 32'h22222222, 0);
        issue(1, 0, 3'd2, 32'h8, 32'h0, 1, 32'h33333333, 0);
        issue(1, 0, 3'd2, 32'hC, 32'h0, 1, 32'h44444444, 0);
        repeat (40) begin
            a = $urandom & 32'hFFFF_F01F;
            issue(1, 1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 9)], a, $urandom);
        end
        idle(1);

        drain(0);
        drain(1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
